// File: rtl/seg7_scan_driver_if.sv
// Bundle between the seven-segment scan driver and its user: digit data and
// masks flow towards the driver, scanned segment/anode drive flows back.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
) ();
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    lz_blank;
    logic [6:0]              segments;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anodes;
    logic                    frame_start;

    modport master (
        output value, blank_mask, blink_mask, dp_mask, lz_blank,
        input  segments, dp, anodes, frame_start
    );

    modport slave (
        input  value, blank_mask, blink_mask, dp_mask, lz_blank,
        output segments, dp, anodes, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scanner: walks NUM_DIGITS hex digits at SCAN_DIV
// clocks per digit, showing a per-frame snapshot with blank/blink/dp/LZ control.
module seg7_scan_driver #(
    parameter int NUM_DIGITS     = 8,
    parameter int SCAN_DIV       = 50000,
    parameter int BLINK_HALF     = 64,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    seg7_scan_driver_if.slave   bus
);
    localparam int PS_W  = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FC_W  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;

    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(BLINK_HALF - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1'b1);
    localparam logic [6:0]            SEG_INV  = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h3F;
            4'h1:    g = 7'h06;
            4'h2:    g = 7'h5B;
            4'h3:    g = 7'h4F;
            4'h4:    g = 7'h66;
            4'h5:    g = 7'h6D;
            4'h6:    g = 7'h7D;
            4'h7:    g = 7'h07;
            4'h8:    g = 7'h7F;
            4'h9:    g = 7'h6F;
            4'hA:    g = 7'h77;
            4'hB:    g = 7'h7C;
            4'hC:    g = 7'h39;
            4'hD:    g = 7'h5E;
            4'hE:    g = 7'h79;
            4'hF:    g = 7'h71;
            default: g = 7'h00;
        endcase
        return g;
    endfunction

    logic [PS_W-1:0]       prescaler_q, prescaler_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic                  phase_q, phase_d;
    logic                  started_q, started_d;
    logic [VAL_W-1:0]      value_snap_q, value_snap_d;
    logic [NUM_DIGITS-1:0] blank_snap_q, blank_snap_d;
    logic [NUM_DIGITS-1:0] blink_snap_q, blink_snap_d;
    logic [NUM_DIGITS-1:0] dp_snap_q, dp_snap_d;
    logic                  lz_snap_q, lz_snap_d;
    logic [6:0]            segments_q, segments_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
    logic                  frame_start_q, frame_start_d;

    logic                  tick_s, wrap_s, dark_s, lz_dark_s;
    logic [VAL_W-1:0]      upper_s;

    // Scan timing, per-frame snapshot and blink phase.
    always_comb begin
        tick_s       = (prescaler_q == PS_LAST);
        wrap_s       = tick_s && (index_q == IDX_LAST);
        prescaler_d  = tick_s ? '0 : prescaler_q + 1'b1;
        index_d      = index_q;
        frame_cnt_d  = frame_cnt_q;
        phase_d      = phase_q;
        started_d    = started_q | wrap_s;
        value_snap_d = value_snap_q;
        blank_snap_d = blank_snap_q;
        blink_snap_d = blink_snap_q;
        dp_snap_d    = dp_snap_q;
        lz_snap_d    = lz_snap_q;
        if (wrap_s) begin
            index_d      = '0;
            value_snap_d = bus.value;
            blank_snap_d = bus.blank_mask;
            blink_snap_d = bus.blink_mask;
            dp_snap_d    = bus.dp_mask;
            lz_snap_d    = bus.lz_blank;
            if (frame_cnt_q == FC_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end else if (tick_s) begin
            index_d = index_q + 1'b1;
        end else begin
            index_d = index_q;
        end
    end

    // Display decode for the currently selected digit; everything stays dark until the first snapshot.
    always_comb begin
        upper_s       = value_snap_q >> {index_q, 2'b00};
        lz_dark_s     = (index_q != '0) && (upper_s == '0);
        dark_s        = !started_q
                        || blank_snap_q[index_q]
                        || (blink_snap_q[index_q] && !phase_q)
                        || (lz_snap_q && lz_dark_s);
        segments_d    = SEG_INV;
        dp_d          = SEG_ACTIVE_LOW;
        anodes_d      = AN_INV;
        frame_start_d = started_q && (index_q == '0) && (prescaler_q == '0);
        if (!dark_s) begin
            segments_d = hex_glyph(upper_s[3:0]) ^ SEG_INV;
            dp_d       = dp_snap_q[index_q] ^ SEG_ACTIVE_LOW;
            anodes_d   = (AN_ONE << index_q) ^ AN_INV;
        end else begin
            segments_d = SEG_INV;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q   <= '0;
            index_q       <= '0;
            frame_cnt_q   <= '0;
            phase_q       <= 1'b1;
            started_q     <= 1'b0;
            value_snap_q  <= '0;
            blank_snap_q  <= '0;
            blink_snap_q  <= '0;
            dp_snap_q     <= '0;
            lz_snap_q     <= 1'b0;
            segments_q    <= SEG_INV;
            dp_q          <= SEG_ACTIVE_LOW;
            anodes_q      <= AN_INV;
            frame_start_q <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            index_q       <= index_d;
            frame_cnt_q   <= frame_cnt_d;
            phase_q       <= phase_d;
            started_q     <= started_d;
            value_snap_q  <= value_snap_d;
            blank_snap_q  <= blank_snap_d;
            blink_snap_q  <= blink_snap_d;
            dp_snap_q     <= dp_snap_d;
            lz_snap_q     <= lz_snap_d;
            segments_q    <= segments_d;
            dp_q          <= dp_d;
            anodes_q      <= anodes_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.segments    = segments_q;
    assign bus.dp          = dp_q;
    assign bus.anodes      = anodes_q;
    assign bus.frame_start = frame_start_q;
endmodule
